axis_rr_arbiter: RTL and testbench
==================================

Name: axis_rr_arbiter

Overview:
- N-input round-robin AXI-Stream packet arbiter that shares one downstream stream sink (the team's AXIS fifo) between several producers.
- Grants one requester per packet and holds the grant until that packet's TLAST beat.
- Enforces a maximum packet length so one source cannot hold the sink forever.
- Sits directly in front of the fifo's slave interface; its master port connects to the fifo S_AXIS_* pins.

Parameters:
- NUM_IN, 4, number of requesting AXIS slave ports (2..16).
- WIDTH, 8, TDATA width in bits, matching the downstream fifo WIDTH.
- MAX_BEATS, 16, maximum beats per granted packet before a forced release (>=1).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- S_AXIS_TVALID  in  NUM_IN  per-port valid; bit i belongs to port i.
- S_AXIS_TDATA  in  NUM_IN*WIDTH  per-port data; port i occupies bits [i*WIDTH +: WIDTH].
- S_AXIS_TLAST  in  NUM_IN  per-port last-beat flag.
- S_AXIS_TREADY  out  NUM_IN  per-port ready; at most one bit is set at any time.
- M_AXIS_TVALID  out  1  valid to the sink.
- M_AXIS_TDATA  out  WIDTH  data to the sink.
- M_AXIS_TLAST  out  1  last-beat flag to the sink.
- M_AXIS_TREADY  in  1  ready from the sink.
- grant_id  out  $clog2(NUM_IN)  index of the granted port; valid while busy=1.
- busy  out  1  high while the block is in XFER.
- trunc_err  out  1  one-cycle pulse after a forced truncation.

Behaviour:
- Reset (rst=1 sampled at posedge) gives the following state on the next cycle:
  - state=IDLE, grant_id=0, last_grant=NUM_IN-1 (port 0 has first priority), beat_cnt=0.
  - busy=0, trunc_err=0.
  - M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, S_AXIS_TREADY=0.
- State machine has two states, IDLE and XFER.
- IDLE:
  - All S_AXIS_TREADY=0, M_AXIS_TVALID=0, TDATA and TLAST driven 0.
  - If any S_AXIS_TVALID is set, register grant_id = first set bit searching last_grant+1, last_grant+2, ... modulo NUM_IN, then go to XFER.
  - Arbitration latency is 1 cycle from valid seen to grant.
- XFER (combinational pass-through of the granted port g):
  - M_AXIS_TVALID = S_AXIS_TVALID[g].
  - M_AXIS_TDATA = S_AXIS_TDATA[g].
  - S_AXIS_TREADY[g] = M_AXIS_TREADY; all other readies are 0.
  - M_AXIS_TLAST = S_AXIS_TLAST[g] OR (beat_cnt == MAX_BEATS-1).
  - Zero added latency, no buffering.
- A handshake is M_AXIS_TVALID & M_AXIS_TREADY.
  - Each handshake increments beat_cnt. beat_cnt width is $clog2(MAX_BEATS+1).
- Packet end is a handshake with M_AXIS_TLAST=1. On packet end:
  - next state IDLE, last_grant <= g, beat_cnt <= 0.
  - There is exactly one idle bubble cycle between consecutive packets.
- Truncation: if packet end is caused by the beat limit while S_AXIS_TLAST[g]=0, then trunc_err=1 for exactly the following cycle.
  - The source's remaining beats are treated as a new packet and must win arbitration again.
- Valid drop mid-packet: grant is held indefinitely; no timeout; beat_cnt unchanged.
- Backpressure: while M_AXIS_TREADY=0, the granted source sees TREADY=0 and must hold its data. No beat is dropped or duplicated.
- Valids on non-granted ports are ignored until the next IDLE; those ports see TREADY=0.
- Reset mid-packet: on the next cycle all outputs are at reset values and the partial packet is abandoned. Priority restarts at port 0.
- Rotating priority guarantees each continuously requesting port is granted within NUM_IN packets.

Test Plan:
- Only port 2 valid with 3-beat packet A,B,C (TLAST on C), M_AXIS_TREADY=1:
  - grant_id=2, busy=1 one cycle after valid;
  - M_AXIS_TDATA A,B,C on consecutive cycles, M_AXIS_TLAST on C;
  - IDLE the next cycle.
- All 4 ports continuously valid with 1-beat packets (TLAST=1):
  - grant order 0,1,2,3,0,1;
  - one packet per 2 cycles;
  - S_AXIS_TREADY one-hot or zero every cycle.
- Port 1 granted, 4-beat packet, M_AXIS_TREADY low for 3 cycles after beat 2:
  - M_AXIS_TDATA holds beat 3 and S_AXIS_TREADY[1]=0 throughout;
  - exactly 4 beats delivered in order.
- MAX_BEATS=4, port 1 sends 6 beats with no TLAST:
  - beat 4 has M_AXIS_TLAST=1, followed by trunc_err pulse and one IDLE cycle;
  - beats 5-6 delivered after regrant to port 1, as the only requester.
- Port 3 finishes a packet while ports 0 and 3 are both valid:
  - next grant is port 0 (wrap-around), then port 3.
- rst=1 asserted during beat 2 of a port 2 packet:
  - next cycle M_AXIS_TVALID=0, busy=0, grant_id=0, all S_AXIS_TREADY=0;
  - after release with ports 1 and 2 valid, port 1 is granted first.

Source files
------------

// File: rtl/axis_rr_arbiter_if.sv
// AXI-Stream bundle carrying N parallel lanes of WIDTH-bit data.
// Lane i of TDATA occupies bits [i*WIDTH +: WIDTH].
interface axis_rr_arbiter_if #(
    parameter int N     = 1,
    parameter int WIDTH = 8
);
    logic [N-1:0]       TVALID;
    logic [N*WIDTH-1:0] TDATA;
    logic [N-1:0]       TLAST;
    logic [N-1:0]       TREADY;

    modport master (
        output TVALID,
        output TDATA,
        output TLAST,
        input  TREADY
    );

    modport slave (
        input  TVALID,
        input  TDATA,
        input  TLAST,
        output TREADY
    );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI-Stream packet arbiter: one grant per packet, held to TLAST
// or to the MAX_BEATS limit, with a zero-latency pass-through while granted.
module axis_rr_arbiter #(
    parameter int NUM_IN    = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    axis_rr_arbiter_if.slave          s_axis,
    axis_rr_arbiter_if.master         m_axis,
    output logic [$clog2(NUM_IN)-1:0] grant_id,
    output logic                      busy,
    output logic                      trunc_err
);
    localparam int IW = $clog2(NUM_IN);
    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] LIM = CW'(MAX_BEATS - 1);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [IW-1:0]   grant_d;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   last_d;
    logic [CW-1:0]   beat_cnt;
    logic [CW-1:0]   cnt_d;
    logic            trunc_d;

    logic [IW-1:0]   pick;
    logic [IW:0]     best;
    logic [IW:0]     off;
    logic [IW:0]     ip;
    logic [IW:0]     lg;

    logic            g_valid;
    logic            g_last;
    logic [WIDTH-1:0] g_data;
    logic            at_lim;

    // Pick the requester at the smallest cyclic distance after last_grant.
    always_comb begin
        pick = '0;
        best = (IW+1)'(NUM_IN + 1);
        off  = '0;
        ip   = '0;
        lg   = {1'b0, last_grant};
        for (int i = 0; i < NUM_IN; i++) begin
            ip = (IW+1)'(i);
            if (ip > lg) begin
                off = ip - lg;
            end else begin
                off = ip + (IW+1)'(NUM_IN) - lg;
            end
            if (s_axis.TVALID[i] && (off < best)) begin
                best = off;
                pick = IW'(i);
            end
        end
    end

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_id == IW'(i)) begin
                g_valid = s_axis.TVALID[i];
                g_last  = s_axis.TLAST[i];
                g_data  = s_axis.TDATA[i*WIDTH +: WIDTH];
            end
        end
    end

    assign at_lim = (beat_cnt == LIM);
    assign busy   = (state == XFER);

    always_comb begin
        state_d       = state;
        grant_d       = grant_id;
        last_d        = last_grant;
        cnt_d         = beat_cnt;
        trunc_d       = 1'b0;
        m_axis.TVALID = 1'b0;
        m_axis.TDATA  = '0;
        m_axis.TLAST  = 1'b0;
        s_axis.TREADY = '0;
        unique case (state)
            IDLE: begin
                if (|s_axis.TVALID) begin
                    grant_d = pick;
                    cnt_d   = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                m_axis.TVALID = g_valid;
                m_axis.TDATA  = g_data;
                m_axis.TLAST  = g_last | at_lim;
                s_axis.TREADY = {{(NUM_IN-1){1'b0}}, m_axis.TREADY} << grant_id;
                if (g_valid && m_axis.TREADY) begin
                    if (g_last || at_lim) begin
                        state_d = IDLE;
                        last_d  = grant_id;
                        cnt_d   = '0;
                        trunc_d = ~g_last;
                    end else begin
                        cnt_d = beat_cnt + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= IW'(NUM_IN - 1);
            beat_cnt   <= '0;
            trunc_err  <= 1'b0;
        end else begin
            state      <= state_d;
            grant_id   <= grant_d;
            last_grant <= last_d;
            beat_cnt   <= cnt_d;
            trunc_err  <= trunc_d;
        end
    end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Randomised scoreboard bench for axis_rr_arbiter against a packet-level
// round-robin model; per-port expected beat queues are drained by a monitor.
module tb_axis_rr_arbiter;
    localparam int NUM_IN    = 4;
    localparam int WIDTH     = 8;
    localparam int MAX_BEATS = 4;
    localparam int IW        = $clog2(NUM_IN);

    logic          clk;
    logic          rst;
    logic [IW-1:0] grant_id;
    logic          busy;
    logic          trunc_err;

    axis_rr_arbiter_if #(.N(NUM_IN), .WIDTH(WIDTH)) s_if ();
    axis_rr_arbiter_if #(.N(1), .WIDTH(WIDTH))      m_if ();

    axis_rr_arbiter #(
        .NUM_IN   (NUM_IN),
        .WIDTH    (WIDTH),
        .MAX_BEATS(MAX_BEATS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_axis   (s_if.slave),
        .m_axis   (m_if.master),
        .grant_id (grant_id),
        .busy     (busy),
        .trunc_err(trunc_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk;
    int n_fail;

    logic [WIDTH:0] srcq [NUM_IN][$];
    logic [WIDTH:0] expq [NUM_IN][$];
    logic [NUM_IN-1:0] hs_s;
    bit gate;
    bit rnd;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endfunction

    // Packet-level model state.
    bit m_ok;
    bit m_busy;
    bit m_trunc;
    bit m_after_rst;
    int m_g;
    int m_last;
    int m_cnt;

    always @(negedge clk) begin
        logic [WIDTH:0]    e;
        logic [NUM_IN-1:0] exp_rdy;
        bit                lastx;
        bit                n_trunc;
        if (m_ok) begin
            chk("busy", busy, m_busy);
            chk("trunc_err", trunc_err, m_trunc);
            chk("tready_onehot0", $onehot0(s_if.TREADY), 1);
            exp_rdy = m_busy ? ({{(NUM_IN-1){1'b0}}, m_if.TREADY} << m_g) : '0;
            chk("s_tready", s_if.TREADY, exp_rdy);
            if (m_after_rst) chk("rst_grant_id", grant_id, 0);
            if (m_busy) begin
                chk("grant_id", grant_id, m_g);
                chk("m_tvalid", m_if.TVALID, s_if.TVALID[m_g]);
                if (s_if.TVALID[m_g]) begin
                    chk("exp_avail", expq[m_g].size() > 0, 1);
                    if (expq[m_g].size() > 0) begin
                        e = expq[m_g][0];
                        lastx = e[WIDTH] || (m_cnt == MAX_BEATS - 1);
                        chk("m_tdata", m_if.TDATA, e[WIDTH-1:0]);
                        chk("m_tlast", m_if.TLAST, lastx);
                    end
                end
            end else begin
                chk("idle_tvalid", m_if.TVALID, 0);
                chk("idle_tdata", m_if.TDATA, 0);
                chk("idle_tlast", m_if.TLAST, 0);
            end
        end
        hs_s = s_if.TVALID & s_if.TREADY;
        n_trunc = 1'b0;
        m_after_rst = 1'b0;
        if (rst) begin
            m_ok = 1'b1;
            m_busy = 1'b0;
            m_g = 0;
            m_last = NUM_IN - 1;
            m_cnt = 0;
            m_after_rst = 1'b1;
        end else if (m_ok) begin
            if (m_busy) begin
                if (s_if.TVALID[m_g] && m_if.TREADY && expq[m_g].size() > 0) begin
                    e = expq[m_g].pop_front();
                    lastx = e[WIDTH] || (m_cnt == MAX_BEATS - 1);
                    if (lastx) begin
                        m_busy = 1'b0;
                        m_last = m_g;
                        m_cnt = 0;
                        n_trunc = !e[WIDTH];
                    end else begin
                        m_cnt++;
                    end
                end
            end else if (|s_if.TVALID) begin
                for (int k = 1; k <= NUM_IN; k++) begin
                    if (s_if.TVALID[(m_last + k) % NUM_IN]) begin
                        m_g = (m_last + k) % NUM_IN;
                        break;
                    end
                end
                m_busy = 1'b1;
                m_cnt = 0;
            end
        end
        m_trunc = n_trunc;
    end

    task automatic push(input int p, input logic [WIDTH-1:0] d, input bit l);
        srcq[p].push_back({l, d});
        expq[p].push_back({l, d});
    endtask

    task automatic push_pkt(input int p, input int len);
        for (int b = 0; b < len; b++) push(p, WIDTH'($urandom), b == len - 1);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_IN; i++)
            if (hs_s[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    endtask

    task automatic drive();
        logic [WIDTH:0] h;
        for (int i = 0; i < NUM_IN; i++) begin
            if (!(s_if.TVALID[i] && !hs_s[i] && srcq[i].size() > 0)) begin
                if (srcq[i].size() > 0 && (!gate || ($urandom % 3 != 0))) begin
                    h = srcq[i][0];
                    s_if.TVALID[i] = 1'b1;
                    s_if.TLAST[i]  = h[WIDTH];
                    s_if.TDATA[i*WIDTH +: WIDTH] = h[WIDTH-1:0];
                end else begin
                    s_if.TVALID[i] = 1'b0;
                    s_if.TLAST[i]  = 1'b0;
                    s_if.TDATA[i*WIDTH +: WIDTH] = '0;
                end
            end
        end
        m_if.TREADY = rnd ? ($urandom % 4 != 0) : 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            advance();
            drive();
        end
    endtask

    task automatic drain(input string name);
        int c;
        int pend;
        c = 0;
        pend = 1;
        while (pend != 0 && c < 2000) begin
            run(1);
            c++;
            pend = busy ? 1 : 0;
            for (int i = 0; i < NUM_IN; i++) pend += srcq[i].size();
        end
        chk(name, c < 2000, 1);
    endtask

    initial begin
        int tot;
        n_chk = 0;
        n_fail = 0;
        gate = 1'b0;
        rnd = 1'b0;
        hs_s = '0;
        rst = 1'b1;
        s_if.TVALID = '0;
        s_if.TDATA = '0;
        s_if.TLAST = '0;
        m_if.TREADY = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        push(2, 8'hA1, 1'b0);
        push(2, 8'hB2, 1'b0);
        push(2, 8'hC3, 1'b1);
        drive();
        @(negedge clk);
        @(negedge clk);
        chk("p2_grant", grant_id, 2);
        chk("p2_busy", busy, 1);
        run(8);

        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NUM_IN; p++) push(p, WIDTH'($urandom), 1'b1);
        run(20);

        push_pkt(1, 6);
        run(14);

        push_pkt(3, 1);
        push_pkt(0, 2);
        push_pkt(3, 2);
        run(12);

        gate = 1'b1;
        rnd = 1'b1;
        repeat (120) begin
            if ($urandom % 2 == 0) push_pkt($urandom % NUM_IN, 1 + $urandom % 7);
            run($urandom % 6);
        end
        drain("drain_rand");

        gate = 1'b0;
        rnd = 1'b0;
        push_pkt(2, 4);
        run(3);
        rst = 1'b1;
        advance();
        rst = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            srcq[i].delete();
            expq[i].delete();
        end
        push(1, 8'h11, 1'b1);
        push(2, 8'h22, 1'b1);
        drive();
        @(negedge clk);
        @(negedge clk);
        chk("rst_regrant", grant_id, 1);
        drain("drain_end");

        tot = 0;
        for (int i = 0; i < NUM_IN; i++) tot += expq[i].size();
        chk("exp_empty", tot, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
